// File: rtl/adder_sched_if.sv
// Handshake and ADDER-control bundle between the job/MUL side, the round scheduler and the ADDER.
interface adder_sched_if;
    logic       job_valid;
    logic       job_ready;
    logic [3:0] job_wsize;
    logic       job_stride;
    logic       mul_valid;
    logic       mul_ready;
    logic       add_valid;
    logic [3:0] add_wsize;
    logic       add_stride;
    logic [2:0] add_wround;
    logic       psum_valid;

    modport master (
        output job_valid, job_wsize, job_stride, mul_valid, psum_valid,
        input  job_ready, mul_ready, add_valid, add_wsize, add_stride, add_wround
    );

    modport slave (
        input  job_valid, job_wsize, job_stride, mul_valid, psum_valid,
        output job_ready, mul_ready, add_valid, add_wsize, add_stride, add_wround
    );
endinterface

// File: rtl/adder_sched.sv
// Round scheduler for the convolution partial-sum ADDER: issues per-round MUL results,
// waits for the single Psum_valid of the job, then retires it.
module adder_sched #(
    parameter int unsigned TIMEOUT = 256,
    parameter int unsigned CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    adder_sched_if.slave     bus,
    output logic             busy,
    output logic             job_done,
    output logic             job_err,
    output logic             timeout_err,
    output logic             spurious_err,
    output logic [CNT_W-1:0] job_cnt
);

    localparam int unsigned TimerW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {StIdle, StIssue, StWait} state_e;

    state_e            state_q, state_d;
    logic [2:0]        round_q, round_d;
    logic [2:0]        last_q, last_d;
    logic [TimerW-1:0] timer_q, timer_d;
    logic [3:0]        wsize_q, wsize_d;
    logic              stride_q, stride_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              tmo_q, tmo_d;
    logic              spur_q, spur_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            round_q  <= '0;
            last_q   <= '0;
            timer_q  <= '0;
            wsize_q  <= '0;
            stride_q <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            tmo_q    <= 1'b0;
            spur_q   <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            round_q  <= round_d;
            last_q   <= last_d;
            timer_q  <= timer_d;
            wsize_q  <= wsize_d;
            stride_q <= stride_d;
            done_q   <= done_d;
            err_q    <= err_d;
            tmo_q    <= tmo_d;
            spur_q   <= spur_d;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        round_d  = round_q;
        last_d   = last_q;
        timer_d  = timer_q;
        wsize_d  = wsize_q;
        stride_d = stride_q;
        done_d   = 1'b0;
        err_d    = 1'b0;
        tmo_d    = tmo_q;
        spur_d   = spur_q;
        cnt_d    = cnt_q;

        unique case (state_q)
            StIdle: begin
                if (bus.job_valid) begin
                    if (bus.job_wsize > 4'd2) begin
                        err_d = 1'b1;
                    end else begin
                        wsize_d  = bus.job_wsize;
                        stride_d = bus.job_stride;
                        round_d  = '0;
                        state_d  = StIssue;
                        // Index of the final round: N-1 for the kernel/stride pair.
                        if (bus.job_wsize == 4'd2) begin
                            last_d = bus.job_stride ? 3'd1 : 3'd3;
                        end else if (bus.job_wsize == 4'd1 && !bus.job_stride) begin
                            last_d = 3'd1;
                        end else begin
                            last_d = 3'd0;
                        end
                    end
                end
            end
            StIssue: begin
                if (bus.mul_valid) begin
                    if (round_q == last_q) begin
                        state_d = StWait;
                        timer_d = '0;
                    end else begin
                        round_d = round_q + 3'd1;
                    end
                end
            end
            StWait: begin
                // psum_valid takes priority over an expiring timer.
                if (bus.psum_valid) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                    cnt_d   = cnt_q + CNT_W'(1);
                end else if (timer_q == TimerW'(TIMEOUT - 1)) begin
                    state_d = StIdle;
                    tmo_d   = 1'b1;
                end else begin
                    timer_d = timer_q + TimerW'(1);
                end
            end
            default: state_d = StIdle;
        endcase

        if (bus.psum_valid && state_q != StWait) begin
            spur_d = 1'b1;
        end
    end

    assign bus.job_ready  = (state_q == StIdle);
    assign bus.mul_ready  = (state_q == StIssue);
    // Combinational so it stays aligned with the bypassing MUL_results bus.
    assign bus.add_valid  = (state_q == StIssue) && bus.mul_valid;
    assign bus.add_wsize  = wsize_q;
    assign bus.add_stride = stride_q;
    assign bus.add_wround = round_q;

    assign busy         = (state_q != StIdle);
    assign job_done     = done_q;
    assign job_err      = err_q;
    assign timeout_err  = tmo_q;
    assign spurious_err = spur_q;
    assign job_cnt      = cnt_q;

endmodule

// File: tb/tb_adder_sched.sv
// Randomized self-checking bench for adder_sched against a job-level reference model.
module tb_adder_sched;
    localparam int unsigned TO = 8;
    localparam int unsigned CW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          busy, job_done, job_err, timeout_err, spurious_err;
    logic [CW-1:0] job_cnt;

    adder_sched_if bus();

    adder_sched #(.TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .bus(bus), .busy(busy), .job_done(job_done),
        .job_err(job_err), .timeout_err(timeout_err), .spurious_err(spurious_err),
        .job_cnt(job_cnt)
    );

    always #5 clk = ~clk;

    int       n_cmp = 0;
    int       n_bad = 0;
    int       exp_cnt = 0;
    logic [3:0] exp_ws = 4'd0;
    logic     exp_st = 1'b0;
    logic     exp_tmo = 1'b0;
    logic     exp_spur = 1'b0;

    // Rounds per job from the kernel size / stride table.
    function automatic int rounds_of(input int ws, input int st);
        int tab [2][3];
        tab = '{'{1, 2, 4}, '{1, 1, 2}};
        return tab[st][ws];
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // pdelay < 0: never answer with psum_valid and expect the timeout instead.
    task automatic run_job(input logic [3:0] ws, input logic st, input int gap, input int pdelay);
        int n;
        int g;
        n = rounds_of(int'(ws), int'(st));
        bus.job_valid = 1'b1; bus.job_wsize = ws; bus.job_stride = st;
        bus.mul_valid = 1'b0; bus.psum_valid = 1'b0;
        #1;
        n_cmp++;
        if (bus.job_ready !== 1'b1) begin
            n_bad++; $display("FAIL accept_ready: job_ready=%b want 1", bus.job_ready);
        end
        tick;
        bus.job_valid = 1'b0;
        exp_ws = ws; exp_st = st;
        #1;
        n_cmp++;
        if (busy !== 1'b1 || bus.job_ready !== 1'b0 || bus.mul_ready !== 1'b1 ||
            bus.add_wsize !== ws || bus.add_stride !== st || bus.add_wround !== 3'd0 ||
            job_done !== 1'b0) begin
            n_bad++;
            $display("FAIL accepted: busy=%b rdy=%b mrdy=%b ws=%0d st=%b wr=%0d done=%b want 1 0 1 %0d %b 0 0",
                     busy, bus.job_ready, bus.mul_ready, bus.add_wsize, bus.add_stride,
                     bus.add_wround, job_done, ws, st);
        end
        for (int r = 0; r < n; r++) begin
            g = (r == 0) ? 0 : ((gap < 0) ? int'($urandom_range(0, 3)) : gap);
            for (int k = 0; k < g; k++) begin
                bus.mul_valid = 1'b0;
                #1;
                n_cmp++;
                if (bus.add_valid !== 1'b0 || bus.add_wround !== 3'(r) || bus.mul_ready !== 1'b1) begin
                    n_bad++;
                    $display("FAIL issue_gap: add_valid=%b wround=%0d mrdy=%b want 0 %0d 1",
                             bus.add_valid, bus.add_wround, bus.mul_ready, r);
                end
                tick;
            end
            bus.mul_valid = 1'b1;
            #1;
            n_cmp++;
            if (bus.add_valid !== 1'b1 || bus.add_wround !== 3'(r) ||
                bus.add_wsize !== ws || bus.add_stride !== st) begin
                n_bad++;
                $display("FAIL issue_round: add_valid=%b wround=%0d ws=%0d st=%b want 1 %0d %0d %b",
                         bus.add_valid, bus.add_wround, bus.add_wsize, bus.add_stride, r, ws, st);
            end
            tick;
        end
        bus.mul_valid = 1'b0;
        if (pdelay >= 0) begin
            for (int d = 0; d < pdelay; d++) begin
                bus.mul_valid = 1'($urandom_range(0, 1));
                #1;
                n_cmp++;
                if (bus.add_valid !== 1'b0 || bus.mul_ready !== 1'b0 || busy !== 1'b1 ||
                    job_done !== 1'b0) begin
                    n_bad++;
                    $display("FAIL wait_psum: add_valid=%b mrdy=%b busy=%b done=%b want 0 0 1 0",
                             bus.add_valid, bus.mul_ready, busy, job_done);
                end
                tick;
            end
            bus.mul_valid = 1'b0;
            bus.psum_valid = 1'b1;
            tick;
            bus.psum_valid = 1'b0;
            exp_cnt++;
            #1;
            n_cmp++;
            if (job_done !== 1'b1 || busy !== 1'b0 || bus.job_ready !== 1'b1 ||
                job_cnt !== CW'(exp_cnt) || bus.add_wsize !== exp_ws ||
                timeout_err !== exp_tmo || spurious_err !== exp_spur) begin
                n_bad++;
                $display("FAIL retire: done=%b busy=%b rdy=%b cnt=%0d ws=%0d tmo=%b spur=%b want 1 0 1 %0d %0d %b %b",
                         job_done, busy, bus.job_ready, job_cnt, bus.add_wsize, timeout_err,
                         spurious_err, exp_cnt, exp_ws, exp_tmo, exp_spur);
            end
        end else begin
            for (int i = 1; i <= int'(TO); i++) begin
                tick;
                n_cmp++;
                if (i < int'(TO)) begin
                    if (timeout_err !== exp_tmo || busy !== 1'b1) begin
                        n_bad++;
                        $display("FAIL timeout_early: tmo=%b busy=%b at %0d want %b 1",
                                 timeout_err, busy, i, exp_tmo);
                    end
                end else begin
                    exp_tmo = 1'b1;
                    if (timeout_err !== 1'b1 || busy !== 1'b0 || job_done !== 1'b0 ||
                        job_cnt !== CW'(exp_cnt)) begin
                        n_bad++;
                        $display("FAIL timeout: tmo=%b busy=%b done=%b cnt=%0d want 1 0 0 %0d",
                                 timeout_err, busy, job_done, job_cnt, exp_cnt);
                    end
                end
            end
        end
    endtask

    task automatic test_reset;
        bus.job_valid = 1'b0; bus.job_wsize = 4'd0; bus.job_stride = 1'b0;
        bus.mul_valid = 1'b0; bus.psum_valid = 1'b0;
        rst = 1'b1;
        tick; tick;
        rst = 1'b0;
        #1;
        n_cmp++;
        if (bus.job_ready !== 1'b1 || bus.mul_ready !== 1'b0 || bus.add_valid !== 1'b0 ||
            bus.add_wsize !== 4'd0 || bus.add_stride !== 1'b0 || bus.add_wround !== 3'd0 ||
            busy !== 1'b0 || job_done !== 1'b0 || job_err !== 1'b0 || timeout_err !== 1'b0 ||
            spurious_err !== 1'b0 || job_cnt !== '0) begin
            n_bad++;
            $display("FAIL reset: rdy=%b mrdy=%b av=%b ws=%0d st=%b wr=%0d busy=%b done=%b err=%b tmo=%b spur=%b cnt=%0d want 1 and rest 0",
                     bus.job_ready, bus.mul_ready, bus.add_valid, bus.add_wsize, bus.add_stride,
                     bus.add_wround, busy, job_done, job_err, timeout_err, spurious_err, job_cnt);
        end
    endtask

    task automatic test_single_3x3;
        run_job(4'd0, 1'b0, 0, 3);
    endtask

    task automatic test_back_to_back;
        run_job(4'd1, 1'b0, 0, 2);
        run_job(4'd2, 1'b0, 0, 1);
    endtask

    task automatic test_gap;
        run_job(4'd2, 1'b1, 3, 2);
    endtask

    task automatic test_illegal;
        for (int i = 0; i < 3; i++) begin
            bus.job_valid = 1'b1;
            bus.job_wsize = (i == 0) ? 4'd5 : 4'($urandom_range(3, 15));
            bus.job_stride = 1'($urandom_range(0, 1));
            tick;
            bus.job_valid = 1'b0;
            #1;
            n_cmp++;
            if (job_err !== 1'b1 || busy !== 1'b0 || bus.job_ready !== 1'b1 ||
                bus.add_wsize !== exp_ws || bus.add_stride !== exp_st) begin
                n_bad++;
                $display("FAIL illegal: err=%b busy=%b rdy=%b ws=%0d st=%b want 1 0 1 %0d %b",
                         job_err, busy, bus.job_ready, bus.add_wsize, bus.add_stride, exp_ws, exp_st);
            end
            tick;
            n_cmp++;
            if (job_err !== 1'b0 || busy !== 1'b0) begin
                n_bad++;
                $display("FAIL illegal_pulse: err=%b busy=%b want 0 0", job_err, busy);
            end
        end
        run_job(4'd1, 1'b1, -1, 4);
    endtask

    task automatic test_psum_timeout_tie;
        run_job(4'd0, 1'b1, 0, int'(TO) - 1);
    endtask

    task automatic test_timeout;
        run_job(4'd1, 1'b0, 1, -1);
        run_job(4'd0, 1'b0, 0, 0);
    endtask

    task automatic test_random;
        for (int j = 0; j < 8; j++) begin
            run_job(4'($urandom_range(0, 2)), 1'($urandom_range(0, 1)), -1,
                    int'($urandom_range(0, 6)));
        end
    endtask

    task automatic test_spurious;
        bus.psum_valid = 1'b1;
        tick;
        bus.psum_valid = 1'b0;
        exp_spur = 1'b1;
        #1;
        n_cmp++;
        if (spurious_err !== 1'b1 || busy !== 1'b0 || job_done !== 1'b0 ||
            job_cnt !== CW'(exp_cnt)) begin
            n_bad++;
            $display("FAIL spurious: spur=%b busy=%b done=%b cnt=%0d want 1 0 0 %0d",
                     spurious_err, busy, job_done, job_cnt, exp_cnt);
        end
    endtask

    task automatic test_reset_mid;
        bus.job_valid = 1'b1; bus.job_wsize = 4'd2; bus.job_stride = 1'b0;
        tick;
        bus.job_valid = 1'b0;
        bus.mul_valid = 1'b1;
        tick;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        exp_cnt = 0; exp_ws = 4'd0; exp_st = 1'b0; exp_tmo = 1'b0; exp_spur = 1'b0;
        #1;
        n_cmp++;
        if (bus.job_ready !== 1'b1 || bus.mul_ready !== 1'b0 || bus.add_valid !== 1'b0 ||
            bus.add_wsize !== 4'd0 || bus.add_wround !== 3'd0 || busy !== 1'b0 ||
            job_done !== 1'b0 || timeout_err !== 1'b0 || spurious_err !== 1'b0 ||
            job_cnt !== '0) begin
            n_bad++;
            $display("FAIL reset_mid: rdy=%b mrdy=%b av=%b ws=%0d wr=%0d busy=%b done=%b tmo=%b spur=%b cnt=%0d want 1 and rest 0",
                     bus.job_ready, bus.mul_ready, bus.add_valid, bus.add_wsize, bus.add_wround,
                     busy, job_done, timeout_err, spurious_err, job_cnt);
        end
        bus.mul_valid = 1'b0;
        tick;
        n_cmp++;
        if (job_done !== 1'b0 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_mid_done: done=%b busy=%b want 0 0", job_done, busy);
        end
        run_job(4'd2, 1'b0, -1, 2);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_3x3();
        test_back_to_back();
        test_gap();
        test_illegal();
        test_psum_timeout_tie();
        test_timeout();
        test_random();
        test_spurious();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
